// File: rtl/cordic_nco_sequencer.sv
// cordic_nco_sequencer
//
// Phase-accumulating NCO front end for an external iterative CORDIC stage.
// A phase accumulator is stepped by ftw once per captured result. Each phase
// is handed to the CORDIC with a one-cycle start pulse. The sine/cosine result
// is then held behind a valid/ready handshake.
//
// Ports
//   CLK, RST_N        rising-edge clock, synchronous active-low reset
//   enable            run free-running phase generation
//   load_phase        load phase_init into the accumulator (aborts any conversion)
//   phase_init, ftw   signed initial phase / phase step per sample (WL bits)
//   cordic_angle      registered angle presented to the CORDIC
//   cordic_start      one-cycle start pulse to the CORDIC
//   cordic_sine/cos   CORDIC results (WO bits, 1.9 signed)
//   cordic_done       CORDIC done level (stale until cleared one cycle after start)
//   out_sine/cos      captured result
//   out_phase         angle that produced the current result
//   out_valid         result held, awaiting out_ready
//   out_ready         downstream accept
//   busy              sequencer not idle
//   timeout_err       sticky: CORDIC never signalled done within TMO wait cycles
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no conversion in flight
// LAUNCH | cordic_start high, cordic_angle = phase
// WAIT   | waiting for a fresh cordic_done (first cycle ignored)
// HOLD   | result valid, waiting for out_ready

module cordic_nco_sequencer #(
    parameter int WL  = 10,
    parameter int WO  = 10,
    parameter int TMO = 31
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 enable,
    input  logic                 load_phase,
    input  logic signed [WL-1:0] phase_init,
    input  logic signed [WL-1:0] ftw,
    output logic signed [WL-1:0] cordic_angle,
    output logic                 cordic_start,
    input  logic signed [WO-1:0] cordic_sine,
    input  logic signed [WO-1:0] cordic_cosine,
    input  logic                 cordic_done,
    output logic signed [WO-1:0] out_sine,
    output logic signed [WO-1:0] out_cosine,
    output logic signed [WL-1:0] out_phase,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TMO = CW'(TMO);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t                state;
    logic signed [WL-1:0]  phase;
    // Holds 1 on the first WAIT cycle, so that cycle is recognisable.
    logic [CW-1:0]         wait_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            phase        <= '0;
            cordic_angle <= '0;
            cordic_start <= 1'b0;
            out_sine     <= '0;
            out_cosine   <= '0;
            out_phase    <= '0;
            out_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            cordic_start <= 1'b0;
            if (load_phase) begin
                // Abort: the in-flight result is simply never captured.
                phase     <= phase_init;
                state     <= IDLE;
                out_valid <= 1'b0;
                wait_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state        <= LAUNCH;
                            cordic_start <= 1'b1;
                            cordic_angle <= phase;
                        end
                    end
                    LAUNCH: begin
                        state    <= WAIT;
                        wait_cnt <= CNT_ONE;
                    end
                    WAIT: begin
                        // done on the first WAIT cycle may be left over from the
                        // previous conversion, so it is not trusted there.
                        if (cordic_done && (wait_cnt != CNT_ONE)) begin
                            out_sine   <= cordic_sine;
                            out_cosine <= cordic_cosine;
                            out_phase  <= cordic_angle;
                            out_valid  <= 1'b1;
                            phase      <= phase + ftw;
                            wait_cnt   <= '0;
                            state      <= HOLD;
                        end else if (wait_cnt == CNT_TMO) begin
                            timeout_err <= 1'b1;
                            wait_cnt    <= '0;
                            state       <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_ONE;
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (enable) begin
                                state        <= LAUNCH;
                                cordic_start <= 1'b1;
                                cordic_angle <= phase;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cordic_nco_sequencer.sv
// Self-checking bench for cordic_nco_sequencer. The CORDIC stand-in has a
// 10-iteration latency. It keeps done high from the previous run and drops it
// one cycle after it sees start. Its results are a simple function of the
// angle, so captured values can be predicted.

module tb_cordic_nco_sequencer;

    localparam int WL  = 10;
    localparam int WO  = 10;
    localparam int TMO = 31;
    localparam int LAT = 10;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic                 enable;
    logic                 load_phase;
    logic signed [WL-1:0] phase_init;
    logic signed [WL-1:0] ftw;
    logic signed [WL-1:0] cordic_angle;
    logic                 cordic_start;
    logic signed [WO-1:0] cordic_sine   = 10'sd77;
    logic signed [WO-1:0] cordic_cosine = -10'sd77;
    logic                 cordic_done   = 1'b1;
    logic signed [WO-1:0] out_sine;
    logic signed [WO-1:0] out_cosine;
    logic signed [WL-1:0] out_phase;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    cordic_nco_sequencer #(.WL(WL), .WO(WO), .TMO(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .load_phase(load_phase),
        .phase_init(phase_init), .ftw(ftw), .cordic_angle(cordic_angle),
        .cordic_start(cordic_start), .cordic_sine(cordic_sine),
        .cordic_cosine(cordic_cosine), .cordic_done(cordic_done),
        .out_sine(out_sine), .out_cosine(out_cosine), .out_phase(out_phase),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic signed [WO-1:0] sine_of(input logic signed [WL-1:0] a);
        return a + 10'sd5;
    endfunction

    function automatic logic signed [WO-1:0] cos_of(input logic signed [WL-1:0] a);
        return a ^ 10'sh155;
    endfunction

    // CORDIC stand-in
    bit                   never_done = 1'b0;
    logic                 m_start_d  = 1'b0;
    int                   m_cnt      = 0;
    logic signed [WL-1:0] m_angle    = '0;

    always @(posedge CLK) begin
        m_start_d <= cordic_start;
        if (cordic_start === 1'b1) begin
            m_cnt   <= LAT;
            m_angle <= cordic_angle;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !never_done) begin
                cordic_done   <= 1'b1;
                cordic_sine   <= sine_of(m_angle);
                cordic_cosine <= cos_of(m_angle);
            end
        end
        if (m_start_d === 1'b1) cordic_done <= 1'b0;
    end

    always @(posedge CLK) if (cordic_start === 1'b1) n_starts <= n_starts + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_start(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40 && !ok) begin
            tick(1);
            cyc++;
            if (cordic_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40 && !ok) begin
            tick(1);
            cyc++;
            if (out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_load(input logic signed [WL-1:0] p);
        phase_init = p;
        load_phase = 1'b1;
        tick(1);
        load_phase = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; enable = 1'b0; load_phase = 1'b0;
        phase_init = '0; ftw = '0; out_ready = 1'b1;
        tick(3);
        n_cmp++; if (cordic_angle !== 10'sd0) begin n_bad++; $display("FAIL reset_angle: got %0d want 0", cordic_angle); end
        n_cmp++; if (cordic_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", cordic_start); end
        n_cmp++; if (out_sine !== 10'sd0 || out_cosine !== 10'sd0) begin n_bad++; $display("FAIL reset_sincos: got %0d/%0d want 0/0", out_sine, out_cosine); end
        n_cmp++; if (out_phase !== 10'sd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", out_phase); end
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: valid=%b busy=%b tmo=%b want 000", out_valid, busy, timeout_err); end
        RST_N = 1'b1;
    endtask

    task automatic test_sequence();
        int cyc;
        bit ok;
        int base;
        logic signed [WL-1:0] exp;
        base = n_starts;
        ftw = 10'sd64; out_ready = 1'b1; enable = 1'b1;
        wait_start(cyc, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_first_start: no start within %0d cycles", cyc); end
        for (int i = 0; i < 5; i++) begin
            exp = 10'(64 * i);
            wait_valid(cyc, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_valid_%0d: no out_valid within %0d cycles", i, cyc); end
            // done appears LAT+1 cycles after start rises, capture costs one more
            n_cmp++; if (cyc != LAT + 2) begin n_bad++; $display("FAIL seq_latency_%0d: got %0d want %0d", i, cyc, LAT + 2); end
            n_cmp++; if (out_phase !== exp) begin n_bad++; $display("FAIL seq_phase_%0d: got %0d want %0d", i, out_phase, exp); end
            n_cmp++; if (out_sine !== sine_of(exp) || out_cosine !== cos_of(exp)) begin n_bad++; $display("FAIL seq_sincos_%0d: got %0d/%0d want %0d/%0d", i, out_sine, out_cosine, sine_of(exp), cos_of(exp)); end
            n_cmp++; if (n_starts != base + i + 1) begin n_bad++; $display("FAIL seq_starts_%0d: got %0d want %0d", i, n_starts - base, i + 1); end
            tick(1);
            n_cmp++; if (cordic_start !== 1'b1 || busy !== 1'b1 || cordic_angle !== 10'(64 * (i + 1))) begin n_bad++; $display("FAIL seq_b2b_%0d: start=%b busy=%b angle=%0d want 1 1 %0d", i, cordic_start, busy, cordic_angle, 64 * (i + 1)); end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok;
        ftw = 10'sd128; out_ready = 1'b1; enable = 1'b1;
        do_load(10'sd448);
        wait_start(cyc, ok);
        n_cmp++; if (!ok || cordic_angle !== 10'sd448) begin n_bad++; $display("FAIL wrap_angle1: ok=%b got %0d want 448", ok, cordic_angle); end
        wait_valid(cyc, ok);
        n_cmp++; if (!ok || out_phase !== 10'sd448) begin n_bad++; $display("FAIL wrap_phase1: ok=%b got %0d want 448", ok, out_phase); end
        tick(1);
        n_cmp++; if (cordic_start !== 1'b1 || cordic_angle !== -10'sd448) begin n_bad++; $display("FAIL wrap_angle2: start=%b got %0d want -448", cordic_start, cordic_angle); end
        wait_valid(cyc, ok);
        n_cmp++; if (!ok || out_phase !== -10'sd448) begin n_bad++; $display("FAIL wrap_phase2: ok=%b got %0d want -448", ok, out_phase); end
        n_cmp++; if (out_sine !== -10'sd443) begin n_bad++; $display("FAIL wrap_sine2: got %0d want -443", out_sine); end
    endtask

    task automatic test_hold_stall();
        int cyc;
        bit ok;
        bit stable;
        int n0;
        ftw = 10'sd3; out_ready = 1'b0; enable = 1'b1;
        do_load(10'sd100);
        wait_start(cyc, ok);
        wait_valid(cyc, ok);
        n_cmp++; if (!ok || out_phase !== 10'sd100) begin n_bad++; $display("FAIL stall_phase: ok=%b got %0d want 100", ok, out_phase); end
        n0 = n_starts;
        stable = 1'b1;
        repeat (5) begin
            tick(1);
            if (out_valid !== 1'b1 || out_phase !== 10'sd100 || out_sine !== 10'sd105 ||
                out_cosine !== cos_of(10'sd100) || cordic_start !== 1'b0) stable = 1'b0;
        end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL stall_stable: valid=%b phase=%0d sine=%0d start=%b", out_valid, out_phase, out_sine, cordic_start); end
        n_cmp++; if (n_starts != n0) begin n_bad++; $display("FAIL stall_nostart: got %0d extra starts want 0", n_starts - n0); end
        out_ready = 1'b1;
        tick(1);
        n_cmp++; if (cordic_start !== 1'b1 || cordic_angle !== 10'sd103 || out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: start=%b angle=%0d valid=%b want 1 103 0", cordic_start, cordic_angle, out_valid); end
    endtask

    task automatic test_ftw_zero();
        int cyc;
        bit ok;
        ftw = 10'sd0; out_ready = 1'b1; enable = 1'b1;
        do_load(-10'sd200);
        wait_start(cyc, ok);
        wait_valid(cyc, ok);
        n_cmp++; if (!ok || out_phase !== -10'sd200) begin n_bad++; $display("FAIL ftw0_phase1: ok=%b got %0d want -200", ok, out_phase); end
        tick(1);
        wait_valid(cyc, ok);
        n_cmp++; if (!ok || out_phase !== -10'sd200) begin n_bad++; $display("FAIL ftw0_phase2: ok=%b got %0d want -200", ok, out_phase); end
    endtask

    task automatic test_enable_drop();
        int cyc;
        bit ok;
        ftw = 10'sd1; out_ready = 1'b1; enable = 1'b1;
        do_load(10'sd20);
        wait_start(cyc, ok);
        tick(3);
        enable = 1'b0;
        wait_valid(cyc, ok);
        n_cmp++; if (!ok || out_phase !== 10'sd20) begin n_bad++; $display("FAIL drop_phase: ok=%b got %0d want 20", ok, out_phase); end
        tick(1);
        n_cmp++; if (busy !== 1'b0 || cordic_start !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drop_idle: busy=%b start=%b valid=%b want 000", busy, cordic_start, out_valid); end
        enable = 1'b1;
        tick(1);
        n_cmp++; if (cordic_start !== 1'b1 || cordic_angle !== 10'sd21) begin n_bad++; $display("FAIL drop_relaunch: start=%b angle=%0d want 1 21", cordic_start, cordic_angle); end
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        logic signed [WL-1:0] p0;
        never_done = 1'b1;
        enable = 1'b0;
        do_load(10'sd0);
        p0 = out_phase;
        ftw = 10'sd5; enable = 1'b1;
        wait_start(cyc, ok);
        enable = 1'b0;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 60 && !ok) begin
            tick(1);
            cyc++;
            if (timeout_err === 1'b1) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_flag: timeout_err never set within %0d cycles", cyc); end
        // WAIT is entered one edge after start is seen, then TMO cycles elapse
        n_cmp++; if (cyc != TMO + 1) begin n_bad++; $display("FAIL tmo_cycles: got %0d want %0d", cyc, TMO + 1); end
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: busy=%b valid=%b want 00", busy, out_valid); end
        n_cmp++; if (out_phase !== p0) begin n_bad++; $display("FAIL tmo_outphase: got %0d want %0d", out_phase, p0); end
        enable = 1'b1;
        tick(1);
        n_cmp++; if (cordic_start !== 1'b1 || cordic_angle !== 10'sd0) begin n_bad++; $display("FAIL tmo_phase_kept: start=%b angle=%0d want 1 0", cordic_start, cordic_angle); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_abort_reset();
        int cyc;
        bit ok;
        bit seen_valid;
        never_done = 1'b0;
        out_ready = 1'b1; ftw = 10'sd10; enable = 1'b1;
        do_load(10'sd50);
        seen_valid = 1'b0;
        wait_start(cyc, ok);
        n_cmp++; if (!ok || cordic_angle !== 10'sd50) begin n_bad++; $display("FAIL abort_angle: ok=%b got %0d want 50", ok, cordic_angle); end
        repeat (4) begin tick(1); if (out_valid !== 1'b0) seen_valid = 1'b1; end
        phase_init = 10'sd300;
        load_phase = 1'b1;
        tick(1);
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || cordic_start !== 1'b0) begin n_bad++; $display("FAIL abort_load: busy=%b valid=%b start=%b want 000", busy, out_valid, cordic_start); end
        load_phase = 1'b0;
        tick(1);
        n_cmp++; if (cordic_start !== 1'b1 || cordic_angle !== 10'sd300) begin n_bad++; $display("FAIL abort_relaunch: start=%b angle=%0d want 1 300", cordic_start, cordic_angle); end
        repeat (4) begin tick(1); if (out_valid !== 1'b0) seen_valid = 1'b1; end
        RST_N = 1'b0;
        enable = 1'b0;
        tick(1);
        n_cmp++; if (cordic_angle !== 10'sd0 || cordic_start !== 1'b0 || out_phase !== 10'sd0) begin n_bad++; $display("FAIL rst_mid_angle: angle=%0d start=%b phase=%0d want 0 0 0", cordic_angle, cordic_start, out_phase); end
        n_cmp++; if (out_sine !== 10'sd0 || out_cosine !== 10'sd0) begin n_bad++; $display("FAIL rst_mid_sincos: got %0d/%0d want 0/0", out_sine, out_cosine); end
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags: busy=%b valid=%b tmo=%b want 000", busy, out_valid, timeout_err); end
        RST_N = 1'b1;
        repeat (20) begin tick(1); if (out_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1; end
        n_cmp++; if (seen_valid) begin n_bad++; $display("FAIL abort_no_valid: got out_valid/busy activity want none"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_hold_stall();
        test_ftw_zero();
        test_enable_drop();
        test_timeout();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_nco_sequencer.md
CORDIC_NCO_SEQUENCER -- requirements
Module: cordic_nco_sequencer

Interface
REQ-001 Parameter WL, default 10: phase/angle word width. Full scale is -512..511, where 256 = pi/2 and -512 = -pi.
REQ-002 Parameter WO, default 10: sine/cosine width, 1 integer bit and 9 fractional bits.
REQ-003 Parameter TMO, default 31: maximum cycles spent waiting for CORDIC done.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST_N  input  1  synchronous active-low reset.
REQ-007 enable  input  1  run free-running phase generation.
REQ-008 load_phase  input  1  load phase_init into the accumulator.
REQ-009 phase_init  input  WL  signed initial phase.
REQ-010 ftw  input  WL  signed frequency tuning word (phase step per sample).
REQ-011 cordic_angle  output  WL  signed angle to the CORDIC stage.
REQ-012 cordic_start  output  1  one-cycle start pulse to the CORDIC stage.
REQ-013 cordic_sine, cordic_cosine  input  WO  signed CORDIC results.
REQ-014 cordic_done  input  1  CORDIC done flag; level, cleared by the CORDIC one cycle after start.
REQ-015 out_sine, out_cosine  output  WO  captured result.
REQ-016 out_phase  output  WL  angle that produced the current result.
REQ-017 out_valid  output  1  result held, awaiting out_ready.
REQ-018 out_ready  input  1  downstream accept.
REQ-019 busy  output  1  FSM is not in IDLE.
REQ-020 timeout_err  output  1  sticky: CORDIC failed to assert done within TMO cycles.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT, HOLD.
REQ-022 IDLE -> LAUNCH when enable=1 and load_phase=0; otherwise the FSM SHALL stay in IDLE.
REQ-023 In LAUNCH, the block SHALL drive cordic_start=1 for exactly one cycle with cordic_angle=phase, then go to WAIT.
REQ-024 cordic_angle SHALL be registered and SHALL stay stable from LAUNCH until the next LAUNCH.
REQ-025 In WAIT, the block SHALL ignore cordic_done on the first WAIT cycle, because of stale done from the previous conversion.
REQ-026 From the second WAIT cycle on, done=1 SHALL capture cordic_sine and cordic_cosine into out_sine and out_cosine, capture the launch phase into out_phase, set out_valid=1, and go to HOLD.
REQ-027 When the result is captured, the accumulator SHALL update in the same cycle: phase <= phase + ftw, modulo 2^WL (natural two's-complement wrap, so +pi wraps to -pi, which is correct for the angle domain).
REQ-028 In HOLD, out_valid=1 and out_ready=1 SHALL clear out_valid. The FSM SHALL then go to LAUNCH if enable=1, else to IDLE.
REQ-029 In HOLD, out_* SHALL be held stable while out_ready=0.
REQ-030 Back-to-back throughput: with out_ready tied high, the FSM SHALL go HOLD -> LAUNCH with no IDLE cycle.
REQ-031 The WAIT counter SHALL count cycles in WAIT. If it reaches TMO without done, the block SHALL set timeout_err=1, leave out_valid=0 and out_* unchanged, leave the phase unchanged, and go to IDLE.
REQ-032 timeout_err SHALL clear only on reset.
REQ-033 load_phase=1 SHALL take priority over enable in every state: phase <= phase_init, the FSM aborts to IDLE, out_valid <= 0, and cordic_start <= 0.
REQ-034 An in-flight CORDIC result that arrives after a load_phase abort SHALL be discarded.
REQ-035 enable deasserted during WAIT SHALL still complete the conversion and HOLD handshake, then go to IDLE.
REQ-036 ftw=0 SHALL produce repeated conversions of the same phase.
REQ-037 The latency from LAUNCH to out_valid SHALL equal the CORDIC done latency + 1 cycle.

Reset
REQ-038 RST_N=0 at a rising edge SHALL force: state=IDLE, phase=0, cordic_angle=0, cordic_start=0, out_sine=0, out_cosine=0, out_phase=0, out_valid=0, busy=0, timeout_err=0, wait counter=0.
REQ-039 Reset asserted mid-conversion SHALL abandon the conversion, and no out_valid SHALL follow.

Verification
REQ-040 Reset, then enable=1, ftw=64, out_ready=1, with a 10-iteration CORDIC model -> out_phase sequence 0, 64, 128, ... and exactly one cordic_start per result.
REQ-041 phase_init=448 and ftw=128 -> the second conversion uses angle -448 (wrap), and out_phase=-448 on the second result.
REQ-042 The CORDIC model holds done=1 from the previous run and drops it one cycle after start -> no premature capture; out_valid rises only on the fresh done.
REQ-043 out_ready=0 for 5 cycles in HOLD -> out_* stable, no new cordic_start; release -> LAUNCH on the next cycle.
REQ-044 The CORDIC model never asserts done -> timeout_err=1 exactly TMO=31 cycles after WAIT entry, FSM in IDLE, out_valid=0.
REQ-045 load_phase pulsed during WAIT, then RST_N=0 during a later WAIT -> no out_valid for the aborted conversions, and every output at its reset value after reset.
